// File: rtl/chirp_sample_engine.sv
// chirp_sample_engine: generates one LoRa-style chirp of N = 2^SF phase samples.
// Each accepted sample tick emits the current phase and advances it by a
// frequency step that grows (or, with the down-chirp option, shrinks) by one
// per sample.
//
// Optional feature macro: CHIRP_DOWNCHIRP_EN
//   defined     -> adds input i_down; when latched high the step is symbol - k.
//   not defined -> i_down is absent and only up-chirps are produced.
//
// Handshake: i_start is a one-cycle request honoured only in IDLE (and only
// while i_abort is low); i_sample_tick_n is an active-low one-cycle tick that
// is consumed only in RUN; o_sample is qualified by the one-cycle strobe
// o_sample_valid, exactly one cycle after the tick that produced it.
module chirp_sample_engine #(
    parameter int SF = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [SF-1:0] i_symbol,
`ifdef CHIRP_DOWNCHIRP_EN
    input  logic          i_down,
`endif
    input  logic          i_abort,
    input  logic          i_sample_tick_n,
    output logic          o_tick_en,
    output logic [SF-1:0] o_sample,
    output logic          o_sample_valid,
    output logic          o_chirp_done,
    output logic          o_busy,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index of the final sample in a chirp (N-1) and a width-matched one.
    localparam logic [SF-1:0] K_LAST = '1;
    localparam logic [SF-1:0] K_ONE  = {{(SF-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic [SF-1:0] r_k;
    logic [SF-1:0] r_phase;
    logic [SF-1:0] r_symbol;
    logic          r_tick_en;
    logic [SF-1:0] r_sample;
    logic          r_sample_valid;
    logic          r_chirp_done;
`ifdef CHIRP_DOWNCHIRP_EN
    logic          r_down;
`endif

    logic          w_tick;
    logic          w_last;
    logic [SF-1:0] w_step;

    assign w_tick = ~i_sample_tick_n;
    assign w_last = (r_k == K_LAST);

    // Frequency step for the current sample; wraps silently at SF bits.
`ifdef CHIRP_DOWNCHIRP_EN
    assign w_step = r_down ? (r_symbol - r_k) : (r_symbol + r_k);
`else
    assign w_step = r_symbol + r_k;
`endif

    // Control FSM with registered outputs, sample index and phase accumulator.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_k            <= '0;
            r_phase        <= '0;
            r_symbol       <= '0;
            r_tick_en      <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_chirp_done   <= 1'b0;
`ifdef CHIRP_DOWNCHIRP_EN
            r_down         <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_sample_valid <= 1'b0;
            r_chirp_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Abort wins over a simultaneous start.
                    if (i_start && !i_abort) begin
                        r_state   <= S_RUN;
                        r_symbol  <= i_symbol;
`ifdef CHIRP_DOWNCHIRP_EN
                        r_down    <= i_down;
`endif
                        r_k       <= '0;
                        r_phase   <= '0;
                        r_tick_en <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        // Any tick in this cycle is dropped with the chirp.
                        r_state   <= S_IDLE;
                        r_tick_en <= 1'b0;
                        r_k       <= '0;
                        r_phase   <= '0;
                    end else if (w_tick) begin
                        r_sample       <= r_phase;
                        r_sample_valid <= 1'b1;
                        r_phase        <= r_phase + w_step;
                        r_k            <= r_k + K_ONE;
                        if (w_last) begin
                            r_tick_en <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Done pulse lands the cycle after the last valid, so the
                    // two strobes never overlap. An abort here suppresses it.
                    r_state      <= S_IDLE;
                    r_chirp_done <= ~i_abort;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_tick_en <= 1'b0;
                end
            endcase
        end
    end

    assign o_tick_en      = r_tick_en;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_chirp_done   = r_chirp_done;
    assign o_busy         = (r_state != S_IDLE);
    assign o_state        = r_state;

endmodule

// File: tb/tb_chirp_sample_engine.sv
// Directed bench for chirp_sample_engine (SF = 7, N = 128).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Expected samples come from the closed form
//   up:   s[n] = n*symbol + n*(n-1)/2   (mod 128)
//   down: s[n] = n*symbol - n*(n-1)/2   (mod 128)
// plus hand-written leading values.
module tb_chirp_sample_engine;

    localparam int SF = 7;
    localparam int N  = 128;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [SF-1:0] symbol;
    logic          abort;
    logic          tick_n;
`ifdef CHIRP_DOWNCHIRP_EN
    logic          down;
`endif
    logic          tick_en;
    logic [SF-1:0] sample;
    logic          sample_valid;
    logic          chirp_done;
    logic          busy;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fails  = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;
    int overlap_cnt = 0;

    chirp_sample_engine #(.SF(SF)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_symbol        (symbol),
`ifdef CHIRP_DOWNCHIRP_EN
        .i_down          (down),
`endif
        .i_abort         (abort),
        .i_sample_tick_n (tick_n),
        .o_tick_en       (tick_en),
        .o_sample        (sample),
        .o_sample_valid  (sample_valid),
        .o_chirp_done    (chirp_done),
        .o_busy          (busy),
        .o_state         (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sample_valid) valid_cnt++;
        if (chirp_done) done_cnt++;
        if (sample_valid && chirp_done) overlap_cnt++;
    end

    function automatic logic [SF-1:0] exp_up(input int sym, input int n);
        int v;
        v = n * sym + (n * (n - 1)) / 2;
        return v[SF-1:0];
    endfunction

    function automatic logic [SF-1:0] exp_down(input int sym, input int n);
        int v;
        v = n * sym - (n * (n - 1)) / 2;
        return v[SF-1:0];
    endfunction

    // One-cycle active-low tick; returns on the falling edge where the
    // resulting sample (if any) is visible.
    task automatic send_tick();
        tick_n = 1'b0;
        @(negedge clk);
        tick_n = 1'b1;
    endtask

    // One-cycle start pulse; returns on the falling edge after acceptance.
    task automatic pulse_start(input logic [SF-1:0] sym);
        start  = 1'b1;
        symbol = sym;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; symbol = '0; abort = 1'b0; tick_n = 1'b1;
`ifdef CHIRP_DOWNCHIRP_EN
        down = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++; if (tick_en !== 1'b0) begin n_fails++; $display("FAIL reset_tick_en: got %b exp 0", tick_en); end
        n_checks++; if (sample !== 7'd0) begin n_fails++; $display("FAIL reset_sample: got %0d exp 0", sample); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b exp 0", sample_valid); end
        n_checks++; if (chirp_done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b exp 0", chirp_done); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (state !== 2'd0) begin n_fails++; $display("FAIL reset_state: got %0d exp 0", state); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL idle_busy: got %b exp 0", busy); end
    endtask

    task automatic test_up_symbol0();
        logic [SF-1:0] hand [0:5];
        int v0, d0;
        hand[0] = 7'd0; hand[1] = 7'd0; hand[2] = 7'd1;
        hand[3] = 7'd3; hand[4] = 7'd6; hand[5] = 7'd10;
        v0 = valid_cnt; d0 = done_cnt;
        pulse_start(7'd0);
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL up0_busy_start: got %b exp 1", busy); end
        n_checks++; if (tick_en !== 1'b1) begin n_fails++; $display("FAIL up0_tick_en: got %b exp 1", tick_en); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fails++; $display("FAIL up0_no_early_valid: got %b exp 0", sample_valid); end
        for (int n = 0; n < N; n++) begin
            send_tick();
            n_checks++; if (sample_valid !== 1'b1) begin n_fails++; $display("FAIL up0_valid n=%0d: got %b exp 1", n, sample_valid); end
            n_checks++; if (sample !== exp_up(0, n)) begin n_fails++; $display("FAIL up0_sample n=%0d: got %0d exp %0d", n, sample, exp_up(0, n)); end
            if (n < 6) begin
                n_checks++; if (sample !== hand[n]) begin n_fails++; $display("FAIL up0_hand n=%0d: got %0d exp %0d", n, sample, hand[n]); end
            end
            if (n < N - 1) repeat (19) @(negedge clk);
        end
        n_checks++; if (tick_en !== 1'b0) begin n_fails++; $display("FAIL up0_tick_en_last: got %b exp 0", tick_en); end
        n_checks++; if (chirp_done !== 1'b0) begin n_fails++; $display("FAIL up0_done_early: got %b exp 0", chirp_done); end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL up0_busy_done_state: got %b exp 1", busy); end
        @(negedge clk);
        n_checks++; if (chirp_done !== 1'b1) begin n_fails++; $display("FAIL up0_done: got %b exp 1", chirp_done); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fails++; $display("FAIL up0_valid_at_done: got %b exp 0", sample_valid); end
        n_checks++; if (sample !== 7'd65) begin n_fails++; $display("FAIL up0_hold: got %0d exp 65", sample); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL up0_busy_end: got %b exp 0", busy); end
        @(negedge clk);
        n_checks++; if (chirp_done !== 1'b0) begin n_fails++; $display("FAIL up0_done_width: got %b exp 0", chirp_done); end
        n_checks++; if (valid_cnt - v0 !== N) begin n_fails++; $display("FAIL up0_valid_count: got %0d exp %0d", valid_cnt - v0, N); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fails++; $display("FAIL up0_done_count: got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_symbol5();
        logic [SF-1:0] hand [0:4];
        int busy_low;
        hand[0] = 7'd0; hand[1] = 7'd5; hand[2] = 7'd11; hand[3] = 7'd18; hand[4] = 7'd26;
        busy_low = 0;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL sym5_busy_before: got %b exp 0", busy); end
        pulse_start(7'd5);
        for (int n = 0; n < N; n++) begin
            if (busy !== 1'b1) busy_low++;
            send_tick();
            if (busy !== 1'b1) busy_low++;
            n_checks++; if (sample !== exp_up(5, n)) begin n_fails++; $display("FAIL sym5_sample n=%0d: got %0d exp %0d", n, sample, exp_up(5, n)); end
            if (n < 5) begin
                n_checks++; if (sample !== hand[n]) begin n_fails++; $display("FAIL sym5_hand n=%0d: got %0d exp %0d", n, sample, hand[n]); end
            end
            @(negedge clk);
        end
        n_checks++; if (busy_low !== 0) begin n_fails++; $display("FAIL sym5_busy_run: got %0d low cycles exp 0", busy_low); end
        n_checks++; if (chirp_done !== 1'b1) begin n_fails++; $display("FAIL sym5_done: got %b exp 1", chirp_done); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL sym5_busy_after: got %b exp 0", busy); end
    endtask

    task automatic test_abort();
        int v0, d0;
        v0 = valid_cnt; d0 = done_cnt;
        pulse_start(7'd3);
        for (int n = 0; n < 10; n++) begin
            send_tick();
            n_checks++; if (sample !== exp_up(3, n)) begin n_fails++; $display("FAIL abort_sample n=%0d: got %0d exp %0d", n, sample, exp_up(3, n)); end
            @(negedge clk);
        end
        abort = 1'b1; tick_n = 1'b0;
        @(negedge clk);
        abort = 1'b0; tick_n = 1'b1;
        n_checks++; if (tick_en !== 1'b0) begin n_fails++; $display("FAIL abort_tick_en: got %b exp 0", tick_en); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL abort_busy: got %b exp 0", busy); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fails++; $display("FAIL abort_tick_dropped: got %b exp 0", sample_valid); end
        repeat (3) @(negedge clk);
        n_checks++; if (valid_cnt - v0 !== 10) begin n_fails++; $display("FAIL abort_valid_count: got %0d exp 10", valid_cnt - v0); end
        n_checks++; if (done_cnt - d0 !== 0) begin n_fails++; $display("FAIL abort_no_done: got %0d exp 0", done_cnt - d0); end
        // Abort together with start in IDLE keeps the engine idle.
        abort = 1'b1; start = 1'b1; symbol = 7'd44;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL abort_start_idle_busy: got %b exp 0", busy); end
        n_checks++; if (tick_en !== 1'b0) begin n_fails++; $display("FAIL abort_start_idle_tick_en: got %b exp 0", tick_en); end
        // Restart begins again at sample 0.
        pulse_start(7'd0);
        for (int n = 0; n < 3; n++) begin
            send_tick();
            n_checks++; if (sample !== exp_up(0, n)) begin n_fails++; $display("FAIL abort_restart n=%0d: got %0d exp %0d", n, sample, exp_up(0, n)); end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL abort_cleanup_busy: got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        int v0, d0;
        v0 = valid_cnt; d0 = done_cnt;
        // Ticks held low through IDLE, RUN and DONE; only RUN ticks count.
        tick_n = 1'b0;
        @(negedge clk);
        n_checks++; if (sample_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_idle_tick: got %b exp 0", sample_valid); end
        pulse_start(7'd9);
        n_checks++; if (sample_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_start_tick: got %b exp 0", sample_valid); end
        for (int n = 0; n < N; n++) begin
            if (n == 40) begin start = 1'b1; symbol = 7'd20; end
            @(negedge clk);
            start = 1'b0;
            n_checks++; if (sample_valid !== 1'b1 || sample !== exp_up(9, n)) begin n_fails++; $display("FAIL b2b_sample n=%0d: got %0d/%b exp %0d/1", n, sample, sample_valid, exp_up(9, n)); end
        end
        @(negedge clk);
        n_checks++; if (sample_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_done_tick: got %b exp 0", sample_valid); end
        n_checks++; if (chirp_done !== 1'b1) begin n_fails++; $display("FAIL b2b_done: got %b exp 1", chirp_done); end
        repeat (2) @(negedge clk);
        tick_n = 1'b1;
        n_checks++; if (valid_cnt - v0 !== N) begin n_fails++; $display("FAIL b2b_valid_count: got %0d exp %0d", valid_cnt - v0, N); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fails++; $display("FAIL b2b_done_count: got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int v0, d0;
        pulse_start(7'd1);
        for (int n = 0; n < 50; n++) begin
            send_tick();
            @(negedge clk);
        end
        tick_n = 1'b0;
        @(negedge clk);
        n_checks++; if (sample !== exp_up(1, 50)) begin n_fails++; $display("FAIL rstmid_sample50: got %0d exp %0d", sample, exp_up(1, 50)); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_cnt; d0 = done_cnt;
        n_checks++; if (tick_en !== 1'b0) begin n_fails++; $display("FAIL rstmid_tick_en: got %b exp 0", tick_en); end
        n_checks++; if (sample !== 7'd0) begin n_fails++; $display("FAIL rstmid_sample: got %0d exp 0", sample); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fails++; $display("FAIL rstmid_valid: got %b exp 0", sample_valid); end
        n_checks++; if (busy !== 1'b0 || state !== 2'd0) begin n_fails++; $display("FAIL rstmid_state: got busy=%b state=%0d exp 0/0", busy, state); end
        repeat (4) @(negedge clk);
        tick_n = 1'b1;
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fails++; $display("FAIL rstmid_no_valid: got %0d exp 0", valid_cnt - v0); end
        n_checks++; if (done_cnt - d0 !== 0) begin n_fails++; $display("FAIL rstmid_no_done: got %0d exp 0", done_cnt - d0); end
        pulse_start(7'd2);
        send_tick();
        send_tick();
        n_checks++; if (sample_valid !== 1'b1 || sample !== 7'd2) begin n_fails++; $display("FAIL rstmid_restart: got %0d/%b exp 2/1", sample, sample_valid); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

`ifdef CHIRP_DOWNCHIRP_EN
    task automatic test_downchirp();
        logic [SF-1:0] hand [0:4];
        hand[0] = 7'd0; hand[1] = 7'd0; hand[2] = 7'd127; hand[3] = 7'd125; hand[4] = 7'd122;
        down = 1'b1;
        pulse_start(7'd0);
        down = 1'b0;
        for (int n = 0; n < 5; n++) begin
            send_tick();
            n_checks++; if (sample !== hand[n]) begin n_fails++; $display("FAIL down_hand n=%0d: got %0d exp %0d", n, sample, hand[n]); end
        end
        for (int n = 5; n < 20; n++) begin
            send_tick();
            n_checks++; if (sample !== exp_down(0, n)) begin n_fails++; $display("FAIL down_sample n=%0d: got %0d exp %0d", n, sample, exp_down(0, n)); end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask
`endif

    task automatic test_no_overlap();
        n_checks++; if (overlap_cnt !== 0) begin n_fails++; $display("FAIL no_overlap: got %0d exp 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_up_symbol0();
        test_symbol5();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef CHIRP_DOWNCHIRP_EN
        test_downchirp();
`endif
        test_no_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/chirp_sample_engine.md
CHIRP_SAMPLE_ENGINE -- requirements
Module: chirp_sample_engine

Interface
REQ-001 Parameter SF, default 7: spreading factor; chirp length N = 2^SF samples; legal range 2..10.
REQ-002 i_clk  input  1  system clock; all logic rising-edge.
REQ-003 i_rst_n  input  1  synchronous, active-low reset.
REQ-004 i_start  input  1  one-cycle request to generate one chirp; sampled only in IDLE.
REQ-005 i_symbol  input  SF  chirp start-frequency offset; latched on accepted i_start.
REQ-006 i_abort  input  1  level; forces return to IDLE.
REQ-007 i_sample_tick_n  input  1  active-low 1-cycle sample-rate pulse from the tick generator.
REQ-008 o_tick_en  output  1  drives the tick generator start input; high means tick generation is allowed.
REQ-009 o_sample  output  SF  current chirp phase sample.
REQ-010 o_sample_valid  output  1  one-cycle strobe qualifying o_sample.
REQ-011 o_chirp_done  output  1  one-cycle pulse after the Nth sample.
REQ-012 o_busy  output  1  high in any state other than IDLE.

Function
REQ-013 States: IDLE, RUN, DONE; encoded in 2 bits.
REQ-014 IDLE -> RUN on i_start=1 and i_abort=0; latch i_symbol; clear sample index k and phase accumulator to 0.
REQ-015 RUN: o_tick_en=1; every cycle with i_sample_tick_n=0 is one tick.
REQ-016 On tick n (0..N-1): o_sample <= phase, o_sample_valid <= 1 at the next edge; latency exactly 1 cycle from tick to valid.
REQ-017 Phase update on each tick: phase <= (phase + f) mod 2^SF, with f = (symbol + k) mod 2^SF, then k <= k + 1.
REQ-018 Sample sequence: phase[0]=0, phase[n+1]=phase[n]+f[n]; all arithmetic SF bits wide, silent wrap-around.
REQ-019 On tick with k = N-1: emit the sample, set o_tick_en <= 0, go to DONE.
REQ-020 DONE lasts 1 cycle: o_chirp_done=1, then IDLE; o_sample holds its last value.
REQ-021 Ticks received in IDLE or DONE are ignored; no sample is produced.
REQ-022 i_start while in RUN or DONE is ignored; i_symbol is not re-latched.
REQ-023 i_abort=1 in RUN: go to IDLE at the next edge with o_tick_en=0, no o_chirp_done, k and phase cleared; a tick in the same cycle is discarded.
REQ-024 i_abort and i_start together in IDLE: stay in IDLE.
REQ-025 o_sample_valid and o_chirp_done are never high in the same cycle.

Reset
REQ-026 i_rst_n=0 at a rising edge: state=IDLE, k=0, phase=0, symbol=0, o_tick_en=0, o_sample=0, o_sample_valid=0, o_chirp_done=0, o_busy=0.
REQ-027 Reset mid-chirp abandons the chirp immediately; no done pulse; reset has priority over every other input.

Configuration
REQ-028 Macro CHIRP_DOWNCHIRP_EN defined: add input i_down (1 bit), latched with i_symbol; when 1, f = (symbol - k) mod 2^SF (down-chirp).
REQ-029 Macro CHIRP_DOWNCHIRP_EN not defined: i_down port absent; only up-chirps are produced; all other behaviour is identical.

Verification
REQ-030 SF=7, i_start with i_symbol=0, ticks every 20 cycles -> o_sample 0,0,1,3,6,10,... (triangular mod 128); 128 valids; o_chirp_done one cycle after the 128th valid.
REQ-031 SF=7, i_symbol=5 -> first samples 0,5,11,18,26; o_busy high from the cycle after i_start until o_chirp_done.
REQ-032 i_abort asserted after the 10th tick -> 10 valids only; o_tick_en low and o_busy low next cycle; no o_chirp_done; the next i_start restarts at sample 0.
REQ-033 Ticks in IDLE, plus i_start during RUN with a different i_symbol -> no extra valids; sequence unchanged.
REQ-034 i_rst_n=0 during the 50th sample -> all outputs at reset values the next cycle; later ticks produce nothing until a new i_start.
REQ-035 With CHIRP_DOWNCHIRP_EN, i_down=1, i_symbol=0 -> samples 0,0,127,125,122.
